// File: rtl/gpu_wb_scheduler_if.sv
// rtl/gpu_wb_scheduler_if.sv - issue and write-back handshake bundle for gpu_wb_scheduler
interface gpu_wb_scheduler_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  issue_valid;
    logic [1:0]            issue_rd;
    logic [1:0]            issue_rs1;
    logic [1:0]            issue_rs2;
    logic                  issue_is_load;
    logic                  issue_stall;

    logic                  alu_wb_valid;
    logic [1:0]            alu_wb_addr;
    logic [DATA_WIDTH-1:0] alu_wb_data;
    logic                  alu_wb_ready;

    logic                  lsu_wb_valid;
    logic [1:0]            lsu_wb_addr;
    logic [DATA_WIDTH-1:0] lsu_wb_data;
    logic                  lsu_wb_ready;

    modport master (
        output issue_valid, issue_rd, issue_rs1, issue_rs2, issue_is_load,
        output alu_wb_valid, alu_wb_addr, alu_wb_data,
        output lsu_wb_valid, lsu_wb_addr, lsu_wb_data,
        input  issue_stall, alu_wb_ready, lsu_wb_ready
    );

    modport slave (
        input  issue_valid, issue_rd, issue_rs1, issue_rs2, issue_is_load,
        input  alu_wb_valid, alu_wb_addr, alu_wb_data,
        input  lsu_wb_valid, lsu_wb_addr, lsu_wb_data,
        output issue_stall, alu_wb_ready, lsu_wb_ready
    );
endinterface

// File: rtl/gpu_wb_scheduler.sv
// rtl/gpu_wb_scheduler.sv - register-file write-port arbiter and load scoreboard for one lane
// GPU_WB_STARVE_EN compiles in the LSU anti-starvation counter and priority override.
module gpu_wb_scheduler #(
    parameter int DATA_WIDTH    = 8,
    parameter int NUM_REGISTERS = 4,
    parameter int STARVE_LIMIT  = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    gpu_wb_scheduler_if.slave        wb,
    output logic                     o_rf_write_en,
    output logic [1:0]               o_rf_write_addr,
    output logic [DATA_WIDTH-1:0]    o_rf_write_data,
    output logic [NUM_REGISTERS-1:0] o_busy_mask
);
    localparam logic [1:0] PROTECTED_ADDR = 2'd2;

    logic [NUM_REGISTERS-1:0] r_busy;
    logic                     r_wen;
    logic [1:0]               r_waddr;
    logic [DATA_WIDTH-1:0]    r_wdata;

    logic                     w_force_lsu;
    logic                     w_alu_grant;
    logic                     w_lsu_grant;
    logic                     w_issue_accept;
    logic [NUM_REGISTERS-1:0] w_busy_next;

`ifdef GPU_WB_STARVE_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] r_starve_cnt;

    assign w_force_lsu = wb.lsu_wb_valid && (r_starve_cnt == LIMIT);

    // Counts consecutive arbitrations the waiting LSU lost; saturates at the limit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_starve_cnt <= '0;
        end else if (w_lsu_grant) begin
            r_starve_cnt <= '0;
        end else if (wb.lsu_wb_valid && (r_starve_cnt != LIMIT)) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end
`else
    // Without the counter the limit has no effect; the ALU always wins.
    assign w_force_lsu = (STARVE_LIMIT < 0);
`endif

    assign w_alu_grant     = wb.alu_wb_valid && !w_force_lsu;
    assign w_lsu_grant     = wb.lsu_wb_valid && !w_alu_grant;
    assign wb.alu_wb_ready = w_alu_grant;
    assign wb.lsu_wb_ready = w_lsu_grant;

    assign wb.issue_stall  = wb.issue_valid &&
                             (r_busy[wb.issue_rs1] | r_busy[wb.issue_rs2] | r_busy[wb.issue_rd]);
    assign w_issue_accept  = wb.issue_valid && !wb.issue_stall;

    // Clear on the edge the register file captures the data; a same-cycle set overrides.
    always_comb begin
        w_busy_next = r_busy;
        if (r_wen) begin
            w_busy_next[r_waddr] = 1'b0;
        end
        if (w_issue_accept && wb.issue_is_load && (wb.issue_rd != PROTECTED_ADDR)) begin
            w_busy_next[wb.issue_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_next;
        end
    end

    // Writes to the protected address are consumed but never reach the register file.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wen   <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else begin
            r_wen <= 1'b0;
            if (w_alu_grant) begin
                r_wen   <= (wb.alu_wb_addr != PROTECTED_ADDR);
                r_waddr <= wb.alu_wb_addr;
                r_wdata <= wb.alu_wb_data;
            end else if (w_lsu_grant) begin
                r_wen   <= (wb.lsu_wb_addr != PROTECTED_ADDR);
                r_waddr <= wb.lsu_wb_addr;
                r_wdata <= wb.lsu_wb_data;
            end
        end
    end

    assign o_rf_write_en   = r_wen;
    assign o_rf_write_addr = r_waddr;
    assign o_rf_write_data = r_wdata;
    assign o_busy_mask     = r_busy;
endmodule

// File: tb/tb_gpu_wb_scheduler.sv
// tb/tb_gpu_wb_scheduler.sv - scoreboard bench for gpu_wb_scheduler: directed scenarios plus randomized traffic
module tb_gpu_wb_scheduler;
    localparam int DW = 8;
    localparam int NR = 4;
    localparam int SL = 3;

    typedef struct packed {
        logic          en;
        logic [1:0]    addr;
        logic [DW-1:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          rf_en;
    logic [1:0]    rf_addr;
    logic [DW-1:0] rf_data;
    logic [NR-1:0] busy;

    gpu_wb_scheduler_if #(.DATA_WIDTH(DW)) ifc ();

    gpu_wb_scheduler #(
        .DATA_WIDTH   (DW),
        .NUM_REGISTERS(NR),
        .STARVE_LIMIT (SL)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .wb             (ifc.slave),
        .o_rf_write_en  (rf_en),
        .o_rf_write_addr(rf_addr),
        .o_rf_write_data(rf_data),
        .o_busy_mask    (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: registers with outstanding loads, expected write-port traffic,
    // and how many arbitrations in a row a waiting LSU has lost.
    wr_t           exp_q[$];
    logic [NR-1:0] m_busy = '0;
    wr_t           m_last = '0;
    int            m_lost = 0;

    initial begin
        forever begin
            @(negedge clk);
            model_step();
        end
    end

    task automatic model_step();
        bit  force_lsu, ga, gl, exp_stall;
        wr_t w;
        w = '0;
        exp_stall = ifc.issue_valid &&
                    (m_busy[ifc.issue_rs1] || m_busy[ifc.issue_rs2] || m_busy[ifc.issue_rd]);
        force_lsu = 1'b0;
`ifdef GPU_WB_STARVE_EN
        force_lsu = ifc.lsu_wb_valid && (m_lost >= SL);
`endif
        ga = ifc.alu_wb_valid && !force_lsu;
        gl = ifc.lsu_wb_valid && !ga;
        check("m_busy_mask", busy, m_busy);
        check("m_issue_stall", ifc.issue_stall, exp_stall);
        check("m_alu_ready", ifc.alu_wb_ready, ga);
        check("m_lsu_ready", ifc.lsu_wb_ready, gl);
        if (reset) begin
            m_busy = '0;
            m_last = '0;
            m_lost = 0;
            exp_q.push_back('0);
            return;
        end
        if (ga) w = '{(ifc.alu_wb_addr != 2'd2), ifc.alu_wb_addr, ifc.alu_wb_data};
        else if (gl) w = '{(ifc.lsu_wb_addr != 2'd2), ifc.lsu_wb_addr, ifc.lsu_wb_data};
        exp_q.push_back(w);
        if (m_last.en) m_busy[m_last.addr] = 1'b0;
        if (ifc.issue_valid && !exp_stall && ifc.issue_is_load && ifc.issue_rd != 2'd2)
            m_busy[ifc.issue_rd] = 1'b1;
        m_last = w;
        if (gl) m_lost = 0;
        else if (ifc.lsu_wb_valid && m_lost < SL) m_lost++;
    endtask

    // Monitor: each cycle the write port must show what the model expected one cycle earlier.
    initial begin
        wr_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sb_rf_write_en", rf_en, e.en);
                if (e.en) begin
                    check("sb_rf_write_addr", rf_addr, e.addr);
                    check("sb_rf_write_data", rf_data, e.data);
                end
            end
        end
    end

    task automatic to_neg();
        @(negedge clk);
    endtask

    task automatic to_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ifc.issue_valid   = 1'b0;
        ifc.issue_rd      = 2'd0;
        ifc.issue_rs1     = 2'd0;
        ifc.issue_rs2     = 2'd0;
        ifc.issue_is_load = 1'b0;
        ifc.alu_wb_valid  = 1'b0;
        ifc.alu_wb_addr   = 2'd0;
        ifc.alu_wb_data   = '0;
        ifc.lsu_wb_valid  = 1'b0;
        ifc.lsu_wb_addr   = 2'd0;
        ifc.lsu_wb_data   = '0;
    endtask

    task automatic set_issue(input bit v, input bit [1:0] rd, input bit [1:0] rs1,
                             input bit [1:0] rs2, input bit ld);
        ifc.issue_valid   = v;
        ifc.issue_rd      = rd;
        ifc.issue_rs1     = rs1;
        ifc.issue_rs2     = rs2;
        ifc.issue_is_load = ld;
    endtask

    task automatic random_phase(input int cycles);
        bit [1:0] pend[$];
        bit acc_alu, acc_lsu, acc_iss;
        for (int c = 0; c < cycles; c++) begin
            to_neg();
            acc_alu = ifc.alu_wb_valid && ifc.alu_wb_ready;
            acc_lsu = ifc.lsu_wb_valid && ifc.lsu_wb_ready;
            acc_iss = ifc.issue_valid && !ifc.issue_stall;
            if (acc_iss && ifc.issue_is_load) pend.push_back(ifc.issue_rd);
            to_drive();
            if (!ifc.alu_wb_valid || acc_alu) begin
                ifc.alu_wb_valid = ($urandom_range(0, 99) < 50);
                ifc.alu_wb_addr  = 2'($urandom_range(0, 3));
                ifc.alu_wb_data  = DW'($urandom);
            end
            if (!ifc.lsu_wb_valid || acc_lsu) begin
                ifc.lsu_wb_data = DW'($urandom);
                if (pend.size() > 0 && $urandom_range(0, 2) != 0) begin
                    ifc.lsu_wb_valid = 1'b1;
                    ifc.lsu_wb_addr  = pend.pop_front();
                end else begin
                    ifc.lsu_wb_valid = ($urandom_range(0, 3) == 0);
                    ifc.lsu_wb_addr  = 2'($urandom_range(0, 3));
                end
            end
            if (!ifc.issue_valid || acc_iss)
                set_issue($urandom_range(0, 99) < 60, 2'($urandom_range(0, 3)),
                          2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                          $urandom_range(0, 99) < 40);
        end
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        to_neg();
        check("reset_busy_mask", busy, 4'b0000);
        check("reset_rf_write_en", rf_en, 1'b0);
        check("reset_rf_write_addr", rf_addr, 2'd0);
        check("reset_rf_write_data", rf_data, 8'h00);
        to_drive();
        reset = 1'b0;

        // Load followed by a RAW-dependent instruction
        set_issue(1, 2'd1, 2'd0, 2'd0, 1);
        to_neg(); check("raw_load_accept", ifc.issue_stall, 1'b0);
        to_drive(); set_issue(1, 2'd3, 2'd1, 2'd0, 0);
        to_neg(); check("raw_busy", busy, 4'b0010); check("raw_stall", ifc.issue_stall, 1'b1);
        to_drive(); ifc.lsu_wb_valid = 1; ifc.lsu_wb_addr = 2'd1; ifc.lsu_wb_data = 8'h5A;
        to_neg(); check("raw_lsu_ready", ifc.lsu_wb_ready, 1'b1);
        to_drive(); ifc.lsu_wb_valid = 0;
        to_neg(); check("raw_wen", rf_en, 1'b1); check("raw_wdata", rf_data, 8'h5A);
        check("raw_still_stalled", ifc.issue_stall, 1'b1);
        to_neg(); check("raw_unstalled", ifc.issue_stall, 1'b0);
        to_drive(); set_issue(0, 0, 0, 0, 0);

        // Protected address write is consumed silently
        ifc.alu_wb_valid = 1; ifc.alu_wb_addr = 2'd2; ifc.alu_wb_data = 8'hFF;
        to_neg(); check("prot_ready", ifc.alu_wb_ready, 1'b1);
        to_drive(); ifc.alu_wb_valid = 0;
        to_neg(); check("prot_no_wen", rf_en, 1'b0); check("prot_busy", busy, 4'b0000);

        // Collision: ALU first, LSU on the following cycle
        to_drive();
        ifc.alu_wb_valid = 1; ifc.alu_wb_addr = 2'd0; ifc.alu_wb_data = 8'h11;
        ifc.lsu_wb_valid = 1; ifc.lsu_wb_addr = 2'd3; ifc.lsu_wb_data = 8'h33;
        to_neg(); check("col_alu_ready", ifc.alu_wb_ready, 1'b1);
        check("col_lsu_wait", ifc.lsu_wb_ready, 1'b0);
        to_drive(); ifc.alu_wb_valid = 0;
        to_neg(); check("col_alu_wr", {rf_en, rf_addr}, {1'b1, 2'd0});
        check("col_lsu_ready", ifc.lsu_wb_ready, 1'b1);
        to_drive(); ifc.lsu_wb_valid = 0;
        to_neg(); check("col_lsu_wr", {rf_en, rf_addr, rf_data}, {1'b1, 2'd3, 8'h33});

        // Starvation: ALU stays valid, LSU waits from cycle 0
        to_drive();
        ifc.alu_wb_valid = 1; ifc.alu_wb_addr = 2'd1;
        ifc.lsu_wb_valid = 1; ifc.lsu_wb_addr = 2'd0; ifc.lsu_wb_data = 8'hC3;
        for (int c = 0; c < 6; c++) begin
            bit exp_lsu;
            ifc.alu_wb_data = 8'(c);
`ifdef GPU_WB_STARVE_EN
            exp_lsu = (c == 3);
`else
            exp_lsu = 1'b0;
`endif
            to_neg();
            if (ifc.lsu_wb_valid) check("starve_lsu_grant", ifc.lsu_wb_ready, exp_lsu);
            check("starve_alu_grant", ifc.alu_wb_ready, !exp_lsu);
            if (ifc.lsu_wb_ready) begin
                to_drive(); ifc.lsu_wb_valid = 0;
            end else begin
                to_drive();
            end
        end
        ifc.alu_wb_valid = 0;
        to_neg();
        if (ifc.lsu_wb_valid) check("starve_lsu_after_alu", ifc.lsu_wb_ready, 1'b1);
        to_drive(); ifc.lsu_wb_valid = 0;

        // Reset with loads outstanding, then a late return
        set_issue(1, 2'd0, 2'd1, 2'd1, 1);
        to_drive(); set_issue(1, 2'd3, 2'd1, 2'd1, 1);
        to_drive(); set_issue(0, 0, 0, 0, 0);
        to_neg(); check("rst_busy_before", busy, 4'b1001);
        to_drive(); reset = 1'b1;
        to_drive(); reset = 1'b0; set_issue(1, 2'd3, 2'd0, 2'd0, 0);
        to_neg(); check("rst_busy_after", busy, 4'b0000); check("rst_wen", rf_en, 1'b0);
        check("rst_unstalled", ifc.issue_stall, 1'b0);
        to_drive(); set_issue(0, 0, 0, 0, 0);
        ifc.lsu_wb_valid = 1; ifc.lsu_wb_addr = 2'd3; ifc.lsu_wb_data = 8'h77;
        to_drive(); ifc.lsu_wb_valid = 0;
        to_neg(); check("rst_late_wr", {rf_en, rf_addr, rf_data}, {1'b1, 2'd3, 8'h77});

        // WAW: ALU op to a register with a load outstanding
        to_drive(); set_issue(1, 2'd0, 2'd1, 2'd1, 1);
        to_drive(); set_issue(1, 2'd0, 2'd1, 2'd1, 0);
        to_neg(); check("waw_stall", ifc.issue_stall, 1'b1);
        to_drive(); ifc.lsu_wb_valid = 1; ifc.lsu_wb_addr = 2'd0; ifc.lsu_wb_data = 8'h42;
        to_neg(); check("waw_stall_grant", ifc.issue_stall, 1'b1);
        to_drive(); ifc.lsu_wb_valid = 0;
        to_neg(); check("waw_stall_wen", ifc.issue_stall, 1'b1); check("waw_wen", rf_en, 1'b1);
        to_neg(); check("waw_released", ifc.issue_stall, 1'b0);
        to_drive(); set_issue(0, 0, 0, 0, 0);

        random_phase(800);
        to_drive(); idle_inputs();
        repeat (4) to_drive();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/gpu_wb_scheduler.md
# gpu_wb_scheduler

Write-back scheduler and load scoreboard for one GPU thread lane. It shares the single write port of `gpu_register_file` between the ALU and the load/store unit (LSU). It tracks registers with outstanding loads and stalls issue on RAW/WAW hazards. It protects the read-only `%threadIdx` register (address 2) from any write.

## Interface
- `DATA_WIDTH`, 8, register/data width
- `NUM_REGISTERS`, 4, register count; addresses are 2 bits
- `STARVE_LIMIT`, 3, number of consecutive lost arbitrations after which a pending LSU write-back gets priority

Ports:
- `clk` in 1: clock
- `reset` in 1: synchronous, active-high
- `issue_valid` in 1: decode presents an instruction
- `issue_rd` in 2: destination register
- `issue_rs1`, `issue_rs2` in 2 each: source registers
- `issue_is_load` in 1: the instruction is a load whose result returns via the LSU
- `issue_stall` out 1: hazard; the instruction is not accepted this cycle
- `alu_wb_valid` in 1, `alu_wb_addr` in 2, `alu_wb_data` in DATA_WIDTH: ALU write-back request
- `alu_wb_ready` out 1: ALU request accepted this cycle
- `lsu_wb_valid` in 1, `lsu_wb_addr` in 2, `lsu_wb_data` in DATA_WIDTH: LSU load-return request
- `lsu_wb_ready` out 1: LSU request accepted this cycle
- `rf_write_en` out 1, `rf_write_addr` out 2, `rf_write_data` out DATA_WIDTH: registered drive to the register-file write port
- `busy_mask` out NUM_REGISTERS: scoreboard; bit i set means a load to register i is outstanding

## Operation
- **Scoreboard**
  - Issue is accepted when `issue_valid && !issue_stall`.
  - An accepted issue with `issue_is_load=1` and `issue_rd!=2` sets `busy_mask[issue_rd]`.
  - `issue_stall = issue_valid && (busy[rs1] | busy[rs2] | busy[rd])`. This is combinational.
- **Clearing busy bits**
  - A busy bit clears on the clock edge where `rf_write_en=1` and `rf_write_addr` equals that register. That is the edge where the register file captures the data.
  - A dependent instruction is therefore unstalled in the cycle after `rf_write_en`, and its combinational read returns the new value.
  - Set and clear of the same bit in one cycle cannot occur, because the issue stalls on a busy `rd`. If it is forced anyway, set wins.
- **Arbitration**
  - At most one request is accepted per cycle. By default the ALU has priority.
  - Handshake: a request is accepted when `valid && ready`. The requester holds valid, address and data stable until accepted.
  - When the starvation counter equals `STARVE_LIMIT` and `lsu_wb_valid=1`, the LSU is granted and `alu_wb_ready=0`.
- **Starvation counter**
  - Width is `$clog2(STARVE_LIMIT+1)`.
  - It increments, saturating, each cycle that `lsu_wb_valid=1` but the ALU is granted.
  - It clears to 0 on any LSU grant.
  - It holds when `lsu_wb_valid=0`.
- **Address 2 protection**
  - An accepted write to address 2 is consumed: ready is high.
  - It produces `rf_write_en=0` for that slot and does not touch the scoreboard.
- **Reset**
  - Reset clears `busy_mask`, the starvation counter, `rf_write_en`, `rf_write_addr` and `rf_write_data` to 0.
  - Loads outstanding at reset are forgotten.
  - LSU returns arriving after reset are written normally; they have no busy bit to clear.

## Timing
- Accept in cycle N → `rf_write_en/addr/data` valid in cycle N+1. The register file writes at the end of N+1.
- `rf_write_en` is high for exactly one cycle per accepted write to a non-protected address.
- Throughput is one write per cycle, with no bubbles between back-to-back grants.
- `issue_stall`, `alu_wb_ready` and `lsu_wb_ready` are combinational from the current inputs and state.
- They never depend combinationally on each other.
- `busy_mask` is a registered output.
- With no valid requester: `rf_write_en=0`, while `rf_write_addr` and `rf_write_data` hold their previous values.

## Configuration
- `GPU_WB_STARVE_EN` defined: the starvation counter and the LSU priority override are compiled in, as described above.
- `GPU_WB_STARVE_EN` undefined:
  - The counter is removed, and `STARVE_LIMIT` is ignored.
  - Fixed ALU priority applies: `lsu_wb_ready = lsu_wb_valid && !alu_wb_valid`.

## Test plan
- **Load/RAW:** issue load rd=1, then issue rs1=1 → `busy_mask=4'b0010` and `issue_stall=1`. LSU returns addr 1, data 8'h5A; `rf_write_en` follows one cycle later with data 8'h5A. Stall drops the next cycle and the read of R1 gives 8'h5A.
- **Protected write:** ALU write to addr 2 with data 8'hFF → `alu_wb_ready=1`, `rf_write_en` stays 0, `busy_mask` unchanged.
- **Collision:** ALU and LSU both valid, to addr 0 and addr 3 → ALU write to addr 0 appears first. The LSU write to addr 3 appears the following cycle, once the ALU deasserts valid.
- **Starvation (macro defined):** ALU valid continuously, LSU valid from cycle 0 → ALU granted cycles 0–2, LSU granted cycle 3, then ALU resumes. Undefined: the LSU is never granted while the ALU stays valid.
- **Reset mid-operation:** busy rd=0 and rd=3, then assert reset for one cycle → `busy_mask=0`, `rf_write_en=0`, issue unstalled. A late LSU return to addr 3 is written with `rf_write_en=1`.
- **WAW:** load rd=0 outstanding, then issue ALU op rd=0 → `issue_stall=1` until the cycle after the load's `rf_write_en`.
